// File: rtl/mdu_unit_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide unit.
// Op, MTHI/MTLO and MFHI/MFLO codes match the decoder's control fields.
package mdu_unit_pkg;

   typedef enum logic [3:0] {
      MDU_MULT  = 4'b0000,
      MDU_MULTU = 4'b0001,
      MDU_DIV   = 4'b0010,
      MDU_DIVU  = 4'b0011,
      MDU_MADD  = 4'b0100,
      MDU_MADDU = 4'b0101,
      MDU_MSUB  = 4'b0110,
      MDU_MSUBU = 4'b0111,
      MDU_DUM   = 4'b1111
   } mdu_op_e;

   typedef enum logic [1:0] {
      MT_HI   = 2'b00,
      MT_LO   = 2'b01,
      MT_NONE = 2'b10
   } mthilo_e;

   typedef enum logic [1:0] {
      MF_NONE = 2'b00,
      MF_HI   = 2'b01,
      MF_LO   = 2'b10
   } mfhilo_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit product/accumulate or {remainder, quotient}.
// Signed divide runs on magnitudes so the single divider stays unsigned.
module mdu_calc
   import mdu_unit_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] result,
   output logic        divzero
);

   logic [63:0] acc;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_signed;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] num;
   logic [31:0] den;
   logic [31:0] uquot;
   logic [31:0] urem;
   logic [31:0] quot;
   logic [31:0] rem;

   assign acc = {hi, lo};

   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   assign div_signed = (op == MDU_DIV);
   assign a_mag      = a[31] ? (~a + 32'd1) : a;
   assign b_mag      = b[31] ? (~b + 32'd1) : b;
   assign num        = div_signed ? a_mag : a;
   assign den        = div_signed ? b_mag : b;
   assign divzero    = is_div_op(op) && (b == 32'd0);

   // Divisor forced non-zero so the divider never sees x/0; result is discarded then.
   assign uquot = num / (divzero ? 32'd1 : den);
   assign urem  = num % (divzero ? 32'd1 : den);

   assign quot = (div_signed && (a[31] ^ b[31])) ? (~uquot + 32'd1) : uquot;
   assign rem  = (div_signed && a[31])           ? (~urem + 32'd1)  : urem;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      result = acc;
      case (op)
         MDU_MULT:  result = prod_s;
         MDU_MULTU: result = prod_u;
         MDU_DIV,
         MDU_DIVU:  result = {rem, quot};
         MDU_MADD:  result = acc + prod_s;
         MDU_MADDU: result = acc + prod_u;
         MDU_MSUB:  result = acc - prod_s;
         MDU_MSUBU: result = acc - prod_u;
         default:   result = acc;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit: owns HI/LO, holds the result until
// the latency counter expires, and reports busy to the hazard unit.
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOpE,
   input  logic [1:0]  MTHILOE,
   input  logic [1:0]  MFHILOE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        ExcFlushE,
   input  logic        MDUCLR,
   output logic        MDUBusyE,
   output logic [31:0] MDU_ResultE,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   mdu_state_e  state;
   mdu_state_e  state_next;
   logic [CW-1:0] count;
   logic [63:0] pending;
   logic        pending_wr;
   logic [63:0] calc_result;
   logic        calc_divzero;
   logic        busy_reg;
   logic        start;
   logic        last;
   logic        done;

   mdu_calc u_calc (
      .op      (MDUOpE),
      .a       (SrcAE),
      .b       (SrcBE),
      .hi      (HI),
      .lo      (LO),
      .result  (calc_result),
      .divzero (calc_divzero)
   );

   assign busy_reg = (state == ST_BUSY);
   assign start    = (MDUOpE <= 4'b0111) && !ExcFlushE && !busy_reg;
   assign MDUBusyE = start | busy_reg;
   assign last     = (count == CW'(1));
   // Cancel outranks completion when both land on the same edge.
   assign done     = busy_reg && last && !MDUCLR;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_BUSY;
         ST_BUSY: if (MDUCLR || last) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         count      <= '0;
         pending    <= '0;
         pending_wr <= 1'b0;
      end else begin
         state <= state_next;
         if (start) begin
            count      <= is_div_op(MDUOpE) ? CW'(DIV_LAT) : CW'(MULT_LAT);
            pending    <= calc_result;
            pending_wr <= !calc_divzero;
         end else if (busy_reg) begin
            count <= MDUCLR ? '0 : count - CW'(1);
         end
      end
   end

   // Completion is assigned last so it overrides a coincident MTHI/MTLO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HI <= '0;
         LO <= '0;
      end else begin
         if (!busy_reg && !ExcFlushE) begin
            case (MTHILOE)
               MT_HI:   HI <= SrcAE;
               MT_LO:   LO <= SrcAE;
               default: ;
            endcase
         end
         if (done && pending_wr) begin
            {HI, LO} <= pending;
         end
      end
   end

   always_comb begin
      MDU_ResultE = 32'd0;
      case (MFHILOE)
         MF_HI:   MDU_ResultE = HI;
         MF_LO:   MDU_ResultE = LO;
         default: MDU_ResultE = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, arithmetic, cancel, flush and reset.
module tb_mdu_unit;
   import mdu_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  MDUOpE;
   logic [1:0]  MTHILOE;
   logic [1:0]  MFHILOE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        ExcFlushE;
   logic        MDUCLR;
   logic        MDUBusyE;
   logic [31:0] MDU_ResultE;
   logic [31:0] HI;
   logic [31:0] LO;

   int total = 0;
   int bad   = 0;

   mdu_unit dut (
      .clk         (clk),
      .reset       (reset),
      .MDUOpE      (MDUOpE),
      .MTHILOE     (MTHILOE),
      .MFHILOE     (MFHILOE),
      .SrcAE       (SrcAE),
      .SrcBE       (SrcBE),
      .ExcFlushE   (ExcFlushE),
      .MDUCLR      (MDUCLR),
      .MDUBusyE    (MDUBusyE),
      .MDU_ResultE (MDU_ResultE),
      .HI          (HI),
      .LO          (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Issues one op right after a rising edge and counts cycles with MDUBusyE high.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
      @(posedge clk); #1;
      MDUOpE = op; SrcAE = a; SrcBE = b;
      @(negedge clk);
      cycles = MDUBusyE ? 1 : 0;
      @(posedge clk); #1;
      MDUOpE = MDU_DUM;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!MDUBusyE) break;
         cycles++;
      end
   endtask

   task automatic write_hilo(input logic [1:0] sel, input logic [31:0] val);
      @(posedge clk); #1;
      MTHILOE = sel; SrcAE = val;
      @(posedge clk); #1;
      MTHILOE = MT_NONE;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++; if (MDUBusyE !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", MDUBusyE); end
      total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=00000000", HI); end
      total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=00000000", LO); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int cyc;
      run_op(MDU_MULT, 32'hFFFFFFFE, 32'h00000003, cyc);
      total++; if (cyc != 6) begin bad++; $display("FAIL mult_busy got=%0d want=6", cyc); end
      total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", HI); end
      total++; if (LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", LO); end
      run_op(MDU_MULTU, 32'hFFFFFFFE, 32'h00000003, cyc);
      total++; if (cyc != 6) begin bad++; $display("FAIL multu_busy got=%0d want=6", cyc); end
      total++; if (HI !== 32'h00000002) begin bad++; $display("FAIL multu_hi got=%h want=00000002", HI); end
      total++; if (LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu_lo got=%h want=fffffffa", LO); end
   endtask

   task automatic test_div;
      int cyc;
      run_op(MDU_DIV, 32'hFFFFFFF9, 32'h00000002, cyc);
      total++; if (cyc != 11) begin bad++; $display("FAIL div_busy got=%0d want=11", cyc); end
      total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", LO); end
      total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", HI); end
      run_op(MDU_DIVU, 32'h00000007, 32'h00000000, cyc);
      total++; if (cyc != 11) begin bad++; $display("FAIL divz_busy got=%0d want=11", cyc); end
      total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL divz_lo got=%h want=fffffffd", LO); end
      total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL divz_hi got=%h want=ffffffff", HI); end
      run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
      total++; if (LO !== 32'h80000000) begin bad++; $display("FAIL divovf_lo got=%h want=80000000", LO); end
      total++; if (HI !== 32'h00000000) begin bad++; $display("FAIL divovf_hi got=%h want=00000000", HI); end
      run_op(MDU_DIVU, 32'hFFFFFFF9, 32'h00000002, cyc);
      total++; if (LO !== 32'h7FFFFFFC) begin bad++; $display("FAIL divu_lo got=%h want=7ffffffc", LO); end
      total++; if (HI !== 32'h00000001) begin bad++; $display("FAIL divu_hi got=%h want=00000001", HI); end
   endtask

   task automatic test_madd;
      int cyc;
      write_hilo(MT_HI, 32'h00001234);
      write_hilo(MT_LO, 32'h00005678);
      @(negedge clk);
      total++; if (HI !== 32'h00001234) begin bad++; $display("FAIL mthi got=%h want=00001234", HI); end
      total++; if (LO !== 32'h00005678) begin bad++; $display("FAIL mtlo got=%h want=00005678", LO); end
      run_op(MDU_MADD, 32'h00000002, 32'h00000003, cyc);
      total++; if (cyc != 6) begin bad++; $display("FAIL madd_busy got=%0d want=6", cyc); end
      total++; if (HI !== 32'h00001234) begin bad++; $display("FAIL madd_hi got=%h want=00001234", HI); end
      total++; if (LO !== 32'h0000567E) begin bad++; $display("FAIL madd_lo got=%h want=0000567e", LO); end
      run_op(MDU_MSUB, 32'h00000001, 32'h0000567F, cyc);
      total++; if (HI !== 32'h00001233) begin bad++; $display("FAIL msub_hi got=%h want=00001233", HI); end
      total++; if (LO !== 32'hFFFFFFFF) begin bad++; $display("FAIL msub_lo got=%h want=ffffffff", LO); end
      @(posedge clk); #1;
      MFHILOE = MF_HI;
      @(negedge clk);
      total++; if (MDU_ResultE !== 32'h00001233) begin bad++; $display("FAIL mfhi got=%h want=00001233", MDU_ResultE); end
      MFHILOE = MF_LO;
      #1;
      total++; if (MDU_ResultE !== 32'hFFFFFFFF) begin bad++; $display("FAIL mflo got=%h want=ffffffff", MDU_ResultE); end
      MFHILOE = MF_NONE;
      #1;
      total++; if (MDU_ResultE !== 32'h0) begin bad++; $display("FAIL mfnone got=%h want=00000000", MDU_ResultE); end
   endtask

   task automatic test_cancel;
      int cyc;
      @(posedge clk); #1;
      MDUOpE = MDU_DIV; SrcAE = 32'd100; SrcBE = 32'd7;
      @(negedge clk);
      total++; if (MDUBusyE !== 1'b1) begin bad++; $display("FAIL clr_issue_busy got=%0b want=1", MDUBusyE); end
      @(posedge clk); #1;
      MDUOpE = MDU_DUM; MDUCLR = 1'b1;
      @(negedge clk);
      total++; if (MDUBusyE !== 1'b1) begin bad++; $display("FAIL clr_cycle_busy got=%0b want=1", MDUBusyE); end
      @(posedge clk); #1;
      MDUCLR = 1'b0;
      @(negedge clk);
      total++; if (MDUBusyE !== 1'b0) begin bad++; $display("FAIL clr_after_busy got=%0b want=0", MDUBusyE); end
      repeat (12) @(negedge clk);
      total++; if (HI !== 32'h00001233) begin bad++; $display("FAIL clr_hi got=%h want=00001233", HI); end
      total++; if (LO !== 32'hFFFFFFFF) begin bad++; $display("FAIL clr_lo got=%h want=ffffffff", LO); end
      run_op(MDU_DIV, 32'd100, 32'd7, cyc);
      total++; if (cyc != 11) begin bad++; $display("FAIL div2_busy got=%0d want=11", cyc); end
      total++; if (LO !== 32'd14) begin bad++; $display("FAIL div2_lo got=%h want=0000000e", LO); end
      total++; if (HI !== 32'd2) begin bad++; $display("FAIL div2_hi got=%h want=00000002", HI); end
   endtask

   task automatic test_flush;
      @(posedge clk); #1;
      MDUOpE = MDU_MULT; SrcAE = 32'd9; SrcBE = 32'd9; ExcFlushE = 1'b1;
      @(negedge clk);
      total++; if (MDUBusyE !== 1'b0) begin bad++; $display("FAIL flush_start got=%0b want=0", MDUBusyE); end
      @(posedge clk); #1;
      MDUOpE = MDU_DUM; MTHILOE = MT_LO; SrcAE = 32'hDEAD;
      @(negedge clk);
      total++; if (MDUBusyE !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b want=0", MDUBusyE); end
      @(posedge clk); #1;
      MTHILOE = MT_NONE; ExcFlushE = 1'b0;
      repeat (8) @(negedge clk);
      total++; if (HI !== 32'd2) begin bad++; $display("FAIL flush_hi got=%h want=00000002", HI); end
      total++; if (LO !== 32'd14) begin bad++; $display("FAIL flush_lo got=%h want=0000000e", LO); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      MDUOpE = MDU_MULT; SrcAE = 32'd5; SrcBE = 32'd7;
      @(posedge clk); #1;
      MDUOpE = MDU_DUM;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1; MFHILOE = MF_LO;
      #1;
      total++; if (MDUBusyE !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", MDUBusyE); end
      total++; if (HI !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h want=00000000", HI); end
      total++; if (LO !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h want=00000000", LO); end
      total++; if (MDU_ResultE !== 32'h0) begin bad++; $display("FAIL rstmid_mflo got=%h want=00000000", MDU_ResultE); end
      @(posedge clk); #1;
      reset = 1'b0; MFHILOE = MF_NONE;
      repeat (8) @(negedge clk);
      total++; if (LO !== 32'h0) begin bad++; $display("FAIL rstmid_late_lo got=%h want=00000000", LO); end
      total++; if (MDUBusyE !== 1'b0) begin bad++; $display("FAIL rstmid_late_busy got=%0b want=0", MDUBusyE); end
   endtask

   initial begin
      reset     = 1'b1;
      MDUOpE    = MDU_DUM;
      MTHILOE   = MT_NONE;
      MFHILOE   = MF_NONE;
      SrcAE     = 32'd0;
      SrcBE     = 32'd0;
      ExcFlushE = 1'b0;
      MDUCLR    = 1'b0;
      repeat (2) @(posedge clk);
      test_reset;
      test_mult;
      test_div;
      test_madd;
      test_cancel;
      test_flush;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU, MTHI/MTLO and MFHI/MFLO.
- Drives MDUBusyE to the hazard/bypass unit. Accepts MDUCLR from it, which cancels an in-flight op when an exception is taken.

Parameters:
- MULT_LAT, 5: busy cycles for mult/madd/msub family, counted after the issue cycle.
- DIV_LAT, 10: busy cycles for div/divu, counted after the issue cycle.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MDUOpE  in  4  op in EX: 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MADD, 0101 MADDU, 0110 MSUB, 0111 MSUBU, 1111 MDU_DUM (none).
- MTHILOE  in  2  00 MTHI, 01 MTLO, 10 none.
- MFHILOE  in  2  00 none, 01 MFHI, 10 MFLO.
- SrcAE  in  32  rs operand, already forwarded.
- SrcBE  in  32  rt operand, already forwarded.
- ExcFlushE  in  1  exception taken this cycle; EX instruction is killed.
- MDUCLR  in  1  cancel the op issued last cycle (now in MEM).
- MDUBusyE  out  1  unit busy or starting.
- MDU_ResultE  out  32  MFHI/MFLO read data.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

Behaviour:
- Reset (async): HI=0, LO=0, busy_reg=0, count=0, pending result=0, MDUBusyE=0.
- Issue condition: start = (MDUOpE<=0111) && !ExcFlushE && !busy_reg.
- Hazard unit guarantees no MDU instruction reaches EX while busy. If MDUOpE<=0111 while busy_reg, it is ignored (defensive).
- Issue edge: operands are latched, the 64-bit result is computed by mdu_calc and held in pending, and count is loaded with MULT_LAT or DIV_LAT. For MADD/MSUB the accumulate uses the HI/LO values present at issue.
- MDUBusyE = start | busy_reg. It is combinational, so the D-stage instruction behind an issuing op stalls in the same cycle.
- States: IDLE and BUSY.
  - IDLE -> BUSY on start.
  - BUSY decrements count each cycle.
  - When count==1: {HI,LO} <= pending on that edge, state returns to IDLE, and MDUBusyE falls the following cycle.
  - Total busy = 1 issue cycle + LAT cycles.
- Cancel: MDUCLR in BUSY returns to IDLE at the next edge and leaves HI/LO unwritten. MDUCLR has priority over completion in the same cycle. MDUCLR in IDLE has no effect.
- MTHI/MTLO: write SrcAE to HI/LO at the edge, only when not busy and !ExcFlushE. MDUCLR does not undo it.
- If MTHI/MTLO and a completing op coincide, the completing op wins. Cannot occur under correct stalling; defined for safety only.
- MFHI/MFLO: MDU_ResultE = HI for 01, LO for 10, 0 for 00. Combinational from the registers; no in-flight bypass, since stalls prevent reads while busy.
- Arithmetic:
  - MULT/MADD/MSUB: signed 32x32 -> 64.
  - *U variants: unsigned.
  - MADD: {HI,LO}+product. MSUB: {HI,LO}-product. Both modulo 2^64.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: busy for DIV_LAT as normal, HI/LO unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reset asserted mid-operation: immediate IDLE, HI/LO cleared.

Decomposition:
- Shared constants go in macro.vh: MDU op codes (including MDU_DUM=4'b1111), MTHILO/MFHILO encodings, default latencies.
- One sub-module, mdu_calc: combinational. Inputs are op, A, B, HI, LO. Outputs are a 64-bit result and a divzero flag.
- mdu_unit holds the FSM, counter and registers.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 -> MDUBusyE high for 6 cycles from issue; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> busy 11 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> HI/LO unchanged, busy 11 cycles.
- MTHI 0x1234, MTLO 0x5678, then MADD 2x3 -> HI=0x1234, LO=0x567E. MSUB 1x0x567F on that state -> HI=0x1233, LO=0xFFFFFFFF.
- DIV issued, MDUCLR the next cycle -> MDUBusyE low one cycle later; HI/LO keep prior values. A second DIV issued afterwards completes normally.
- MULT with ExcFlushE=1 in the issue cycle -> no start; MDUBusyE low except the combinational start term, which is 0 here; HI/LO unchanged.
- reset pulsed mid-MULT at count=3 -> MDUBusyE=0 and HI=LO=0 immediately; MFLO read returns 0.
